i2s_slave_rx: RTL and testbench

I2S receiver (slave) that captures an externally clocked stereo I2S stream into the system clock domain. It synchronises `i2s_sclk`, `i2s_lrclk` and `i2s_sdata`, and deserialises left and right words. Each complete frame is presented as one 48-bit sample, {left[47:24], right[23:0]}, over a valid/ready handshake, matching the 48-bit audio FIFO word format. It is intended to feed an sfifo instance in the audio-input path, with status bits exposed through a wishbone regfile.

---
 rtl/audio_pkg.sv | 16 +
 rtl/i2s_rx_sync.sv | 42 ++++
 rtl/i2s_slave_rx.sv | 202 ++++++++++++++++++++
 tb/tb_i2s_slave_rx.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default I2S word/slot sizing, the receiver
// state encoding and the 48-bit sample width used by the audio FIFO and the
// wishbone regfile.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_BITS = 24;
  localparam int unsigned AUDIO_SLOT_MAX  = 32;
  localparam int unsigned AUDIO_SAMPLE_W  = 2 * AUDIO_DATA_BITS;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the external I2S lines into the clk domain.
//   clk, rst                         : system clock, async active-high reset
//   i2s_sclk, i2s_lrclk, i2s_sdata   : raw external I2S lines
//   sclk_rise                        : one-cycle strobe on synchronised sclk 0->1
//   lrclk_s, sdata_s                 : synchronised word select / data
// lrclk and sdata pass through the same two-flop depth as sclk, so the values
// seen alongside sclk_rise are the ones present at the external rising edge.
module i2s_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i2s_sclk,
  input  logic i2s_lrclk,
  input  logic i2s_sdata,
  output logic sclk_rise,
  output logic lrclk_s,
  output logic sdata_s
);

  logic [1:0] sclk_ff;
  logic [1:0] lrclk_ff;
  logic [1:0] sdata_ff;
  logic       sclk_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_ff  <= '0;
      lrclk_ff <= '0;
      sdata_ff <= '0;
      sclk_d   <= 1'b0;
    end else begin
      sclk_ff  <= {sclk_ff[0], i2s_sclk};
      lrclk_ff <= {lrclk_ff[0], i2s_lrclk};
      sdata_ff <= {sdata_ff[0], i2s_sdata};
      sclk_d   <= sclk_ff[1];
    end
  end

  assign sclk_rise = sclk_ff[1] & ~sclk_d;
  assign lrclk_s   = lrclk_ff[1];
  assign sdata_s   = sdata_ff[1];

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: deserialises a stereo I2S stream into {left, right}
// samples delivered over a valid/ready handshake.
//   clk, rst        : system clock, async active-high reset
//   enable          : low = idle, partial frame flushed, sample_valid cleared
//   clear_status    : pulse, clears overrun / frame_err (a coincident set wins)
//   i2s_sclk/lrclk/sdata : external I2S lines (asynchronous to clk)
//   sample_data     : {left, right}, each channel MSB-aligned, zero padded
//   sample_valid    : sample_data holds an unconsumed frame
//   sample_ready    : consumer accepts when valid && ready
//   locked          : aligned to frame boundaries and capturing
//   overrun         : sticky, a completed frame was dropped
//   frame_err       : sticky, a slot exceeded SLOT_MAX bits
module i2s_slave_rx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_BITS = AUDIO_DATA_BITS,
  parameter int unsigned SLOT_MAX  = AUDIO_SLOT_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear_status,
  input  logic                   i2s_sclk,
  input  logic                   i2s_lrclk,
  input  logic                   i2s_sdata,
  output logic [2*DATA_BITS-1:0] sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   locked,
  output logic                   overrun,
  output logic                   frame_err
);

  localparam int unsigned          CNT_W    = $clog2(SLOT_MAX + 2);
  localparam logic [CNT_W-1:0]     CNT_SAT  = CNT_W'(SLOT_MAX + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SLOT_MAX);
  localparam logic [DATA_BITS-1:0] MSB_BIT  = {1'b1, {(DATA_BITS-1){1'b0}}};

  logic sclk_rise;
  logic lrclk_s;
  logic sdata_s;

  i2s_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .i2s_sclk  (i2s_sclk),
    .i2s_lrclk (i2s_lrclk),
    .i2s_sdata (i2s_sdata),
    .sclk_rise (sclk_rise),
    .lrclk_s   (lrclk_s),
    .sdata_s   (sdata_s)
  );

  // lrclk sampled at the previous two sclk edges. With the I2S one-bit delay
  // the bit arriving now is tagged lr_d1 and the previous bit was tagged lr_d2.
  logic lr_d1;
  logic lr_d2;

  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] bit_mask;
  logic [DATA_BITS-1:0] left_q;
  logic [CNT_W-1:0]     bit_cnt;

  rx_state_e state_q;
  rx_state_e state_d;

  logic boundary;
  logic left_start;
  logic left_load;
  logic frame_done;
  logic err_evt;

  assign boundary   = (lr_d1 != lr_d2);
  assign left_start = boundary & lr_d2 & ~lr_d1;
  assign locked     = (state_q != SYNC_WAIT);

  // Tag history runs regardless of enable so a re-enable can align on the
  // very next left-word start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_d1 <= 1'b0;
      lr_d2 <= 1'b0;
    end else if (sclk_rise) begin
      lr_d1 <= lrclk_s;
      lr_d2 <= lr_d1;
    end
  end

  // Bits are written straight into their MSB-aligned slot via a walking mask;
  // once the mask empties, surplus bits are ignored, and short words keep
  // their zero LSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_mask <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      shreg    <= '0;
      bit_mask <= '0;
      bit_cnt  <= '0;
    end else if (sclk_rise) begin
      if (boundary) begin
        shreg    <= sdata_s ? MSB_BIT : '0;
        bit_mask <= MSB_BIT >> 1;
        bit_cnt  <= CNT_W'(1);
      end else begin
        shreg    <= shreg | (bit_mask & {DATA_BITS{sdata_s}});
        bit_mask <= bit_mask >> 1;
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    left_load  = 1'b0;
    frame_done = 1'b0;
    err_evt    = 1'b0;
    if (!enable) begin
      state_d = SYNC_WAIT;
    end else if (sclk_rise) begin
      unique case (state_q)
        SYNC_WAIT: begin
          if (left_start) begin
            state_d = LEFT;
          end
        end
        LEFT: begin
          if (boundary) begin
            left_load = 1'b1;
            state_d   = RIGHT;
          end else if (bit_cnt == CNT_LAST) begin
            err_evt = 1'b1;
            state_d = SYNC_WAIT;
          end
        end
        RIGHT: begin
          if (boundary) begin
            frame_done = 1'b1;
            state_d    = LEFT;
          end else if (bit_cnt == CNT_LAST) begin
            err_evt = 1'b1;
            state_d = SYNC_WAIT;
          end
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q <= '0;
    end else if (left_load) begin
      left_q <= shreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      if (!enable) begin
        sample_valid <= 1'b0;
      end else if (frame_done) begin
        // A same-cycle accept frees the holding register for the new frame.
        if (!sample_valid || sample_ready) begin
          sample_data  <= {left_q, shreg};
          sample_valid <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (frame_done && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (clear_status) begin
        overrun <= 1'b0;
      end

      if (err_evt) begin
        frame_err <= 1'b1;
      end else if (clear_status) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave_rx.sv
module tb_i2s_slave_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear_status;
  logic        i2s_sclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic [47:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        locked;
  logic        overrun;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  bit   rand_ready = 1'b0;
  logic ready_fix  = 1'b1;

  // Serial stream to transmit: channel tag and data bit per sclk period.
  bit          tag_q[$];
  bit          dat_q[$];
  logic [47:0] exp_q[$];
  logic [47:0] got_q[$];

  always #5 clk = ~clk;

  i2s_slave_rx #(.DATA_BITS(24), .SLOT_MAX(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clear_status (clear_status),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .locked       (locked),
    .overrun      (overrun),
    .frame_err    (frame_err)
  );

  initial begin
    sample_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      sample_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && sample_valid && sample_ready) got_q.push_back(sample_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected channel value: the first min(slot, 24) transmitted bits, MSB first.
  function automatic logic [23:0] chan_exp(input logic [31:0] v, input int w);
    logic [31:0] m;
    logic [31:0] kept;
    m    = (w >= 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> w);
    kept = v & m;
    return kept[31:8];
  endfunction

  task automatic add_slot(input bit t, input logic [31:0] v, input int w);
    for (int i = 0; i < w; i++) begin
      tag_q.push_back(t);
      dat_q.push_back(v[31-i]);
    end
  endtask

  task automatic add_frame(input logic [31:0] l, input logic [31:0] r, input int w, input bit expect_it);
    add_slot(1'b0, l, w);
    add_slot(1'b1, r, w);
    if (expect_it) exp_q.push_back({chan_exp(l, w), chan_exp(r, w)});
  endtask

  // lrclk leads the data by one bit: it carries the tag of the next bit.
  task automatic send(input int lim);
    int n;
    n = (lim < 0 || lim > tag_q.size()) ? tag_q.size() : lim;
    for (int k = 0; k < n; k++) begin
      i2s_lrclk = (k + 1 < tag_q.size()) ? tag_q[k+1] : tag_q[k];
      i2s_sdata = dat_q[k];
      #80 i2s_sclk = 1'b1;
      #80 i2s_sclk = 1'b0;
    end
    tag_q.delete();
    dat_q.delete();
  endtask

  task automatic compare(input string tag);
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_frame%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic flush();
    @(posedge clk);
    #1 enable = 1'b0;
    repeat (4) @(posedge clk);
    #1 enable = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 clear_status = 1'b1;
    @(posedge clk);
    #1 clear_status = 1'b0;
  endtask

  initial begin
    int          w;
    int          nf;
    logic [31:0] l;
    logic [31:0] r;

    rst = 1'b1; enable = 1'b0; clear_status = 1'b0;
    i2s_sclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_valid",  64'(sample_valid), 64'd0);
    check("rst_data",   64'(sample_data),  64'd0);
    check("rst_locked", 64'(locked),       64'd0);
    check("rst_overrun",64'(overrun),      64'd0);
    check("rst_ferr",   64'(frame_err),    64'd0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #3;

    // Nominal 32-bit slots, stream starts at a left word: first frame is lost.
    for (int f = 0; f < 3; f++) add_frame(32'hA5A5A500, 32'h3C3C3C00, 32, f > 0);
    add_slot(1'b0, 32'h0, 2);
    send(-1);
    check("t1_data",   64'(sample_data), 64'h0000_A5A5A53C3C3C);
    check("t1_locked", 64'(locked),      64'd1);
    compare("t1");

    // 16-bit slots, left-aligned and zero padded.
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_frame(32'h8001_0000, 32'h7FFF_0000, 16, 1'b1);
    add_frame(32'h8001_0000, 32'h7FFF_0000, 16, 1'b1);
    add_slot(1'b0, 32'h0, 2);
    send(-1);
    check("t2_data", 64'(sample_data), 64'h0000_8001007FFF00);
    compare("t2");

    // Back-pressure: held sample kept, later frames dropped, overrun sticky.
    flush();
    ready_fix = 1'b0;
    repeat (4) @(posedge clk);
    add_slot(1'b1, 32'h0, 4);
    add_frame(32'h11111100, 32'h22222200, 32, 1'b1);
    add_frame($urandom, $urandom, 32, 1'b0);
    add_frame($urandom, $urandom, 32, 1'b0);
    add_slot(1'b0, 32'h0, 2);
    send(-1);
    #1;
    check("t3_valid",   64'(sample_valid), 64'd1);
    check("t3_data",    64'(sample_data),  64'h0000_111111222222);
    check("t3_overrun", 64'(overrun),      64'd1);
    check("t3_nocons",  64'(got_q.size()), 64'd0);
    pulse_clear();
    check("t3_ovr_clr", 64'(overrun), 64'd0);
    ready_fix = 1'b1;
    compare("t3");

    // Stuck lrclk: framing error, then recovery at the next left start.
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_frame($urandom, $urandom, 32, 1'b1);
    add_slot(1'b0, 32'h0, 2);
    send(-1);
    add_slot(1'b0, 32'h0, 40);
    send(-1);
    #1;
    check("t4_ferr",   64'(frame_err), 64'd1);
    check("t4_unlock", 64'(locked),    64'd0);
    add_slot(1'b1, 32'h0, 4);
    add_frame($urandom, $urandom, 32, 1'b1);
    add_frame($urandom, $urandom, 32, 1'b1);
    add_slot(1'b0, 32'h0, 2);
    send(-1);
    #1;
    check("t4_relock",   64'(locked),    64'd1);
    check("t4_ferr_stk", 64'(frame_err), 64'd1);
    compare("t4");
    pulse_clear();
    check("t4_ferr_clr", 64'(frame_err), 64'd0);

    // Enable dropped mid-right-word: that frame is never delivered.
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_frame($urandom, $urandom, 32, 1'b1);
    add_frame($urandom, $urandom, 32, 1'b0);
    send(4 + 64 + 32 + 10);
    flush();
    add_slot(1'b1, 32'h0, 4);
    add_frame($urandom, $urandom, 32, 1'b1);
    add_slot(1'b0, 32'h0, 2);
    send(-1);
    compare("t5");

    // Asynchronous reset mid-frame.
    flush();
    ready_fix = 1'b0;
    repeat (4) @(posedge clk);
    add_slot(1'b1, 32'h0, 4);
    add_frame($urandom, $urandom, 32, 1'b0);
    add_frame($urandom, $urandom, 32, 1'b0);
    add_frame($urandom, $urandom, 32, 1'b0);
    send(4 + 128 + 40);
    #1;
    check("t6_pre_valid", 64'(sample_valid), 64'd1);
    check("t6_pre_ovr",   64'(overrun),      64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_valid",  64'(sample_valid), 64'd0);
    check("t6_data",   64'(sample_data),  64'd0);
    check("t6_locked", 64'(locked),       64'd0);
    check("t6_ovr",    64'(overrun),      64'd0);
    check("t6_ferr",   64'(frame_err),    64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ready_fix = 1'b1;
    repeat (4) @(posedge clk);
    add_slot(1'b1, 32'h0, 4);
    add_frame($urandom, $urandom, 32, 1'b1);
    add_frame($urandom, $urandom, 32, 1'b1);
    add_slot(1'b0, 32'h0, 2);
    send(-1);
    compare("t6");

    // Randomised bursts: slot widths, word values and ready pattern.
    for (int b = 0; b < 6; b++) begin
      flush();
      rand_ready = 1'b1;
      case ($urandom_range(0, 2))
        0:       w = 16;
        1:       w = 24;
        default: w = 32;
      endcase
      nf = int'($urandom_range(2, 3));
      add_slot(1'b1, 32'h0, 4);
      for (int f = 0; f < nf; f++) begin
        l = $urandom;
        r = $urandom;
        add_frame(l, r, w, 1'b1);
      end
      add_slot(1'b0, 32'h0, 2);
      send(-1);
      compare($sformatf("rnd%0d_w%0d", b, w));
      rand_ready = 1'b0;
    end
    check("end_overrun", 64'(overrun), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
